alu_muldiv_iter: RTL and testbench
==================================

# alu_muldiv_iter

Parametrised iterative multiply/divide execution unit. It is the multi-cycle companion to the single-cycle integer ALU in the execute stage. It takes RV32M/RV64M operations using the same 6-bit aluop encoding, computes them with a shift-add multiplier or a restoring divider over XLEN cycles, and returns results through valid/ready handshakes. This replaces the single-cycle multiplier and divider on the critical path, and adds flush support and RISC-V-compliant corner cases.

## Interface
Parameters:
- XLEN, 32, operand/result width; even, ≥ 8.
- TAG_W, 5, width of the opaque tag (destination register) carried with each op.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  kill in-flight op (pipeline redirect).
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept (high only in IDLE).
- in_aluop  in  6  operation code.
- in_a  in  XLEN  rs1 operand.
- in_b  in  XLEN  rs2 operand.
- in_tag  in  TAG_W  tag, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- out_div_zero  out  1  divisor was zero (div/divu/rem/remu only).
- out_illegal  out  1  aluop was not a mul/div code.

## Operation
- Opcodes: 16 mulh, 17 mulhsu, 18 mulhu, 22 mul, 24 div, 26 divu, 28 rem, 30 remu.
- States: IDLE, CALC, DONE.
- IDLE → CALC on in_valid & in_ready. At that edge the unit latches tag and op, stores operand magnitudes and sign flags, and sets count = XLEN.
  - Signedness:
    - mulh, div, rem: both operands signed.
    - mulhsu: a signed, b unsigned.
    - mulhu, divu, remu: both unsigned.
    - mul: product low half is sign-independent.
- CALC performs one iteration per cycle and decrements count. When count reaches 1, the edge goes to DONE with the fixed-up result registered.
- Multiply: shift-add on magnitudes into a 2·XLEN accumulator. Negate the full product if the operand signs differ. mul returns [XLEN-1:0]; mulh* return [2·XLEN-1:XLEN].
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Quotient sign = sign_a ^ sign_b.
  - Remainder takes the sign of the dividend.
- Short-circuit cases skip CALC: IDLE → DONE directly at the accept edge.
  - Divisor 0: quotient = all ones; remainder = in_a; out_div_zero = 1.
  - Signed overflow (a = most-negative, b = −1, div/rem only): quotient = in_a; remainder = 0.
  - Illegal aluop: result 0; out_illegal = 1.
- DONE: out_valid = 1. Goes to IDLE on out_ready.
- flush: synchronous, highest priority after reset. From any state the next state is IDLE, out_valid drops, and the result is discarded. flush and in_valid in the same cycle means no accept.
- Reset values: state IDLE; out_valid, out_div_zero, out_illegal = 0; out_result = 0; out_tag = 0; in_ready = 1 after reset is released.

## Timing
- Latency: the normal path gives out_valid exactly XLEN cycles after the accept edge. The short-circuit path gives out_valid 1 cycle after the accept edge.
- Throughput: one op per XLEN+1 cycles minimum, because in_ready is low in CALC and DONE. There is no accept in the cycle a result is consumed.
- Backpressure: in DONE with out_ready low, out_result, out_tag and the flags hold stable indefinitely.
- in_ready is a registered function of state. Operands are sampled only at the accept edge, so later changes are ignored.
- Reset mid-CALC or mid-DONE: IDLE on the next edge, no output.

## Structure
- Shared package alu_pkg:
  - aluop constants (ALUOP_MUL, ALUOP_MULH, ALUOP_DIV, …), shared with the single-cycle ALU decoder.
  - state enum {IDLE, CALC, DONE}.
- One sub-module: muldiv_fixup, combinational. Inputs are the raw product/quotient/remainder, sign flags and op. Output is the final XLEN result. This keeps the sign and half-select logic out of the FSM.
- Counter width: $clog2(XLEN)+1.

## Test plan
- mul 7 × 0xFFFFFFFD → 0xFFFFFFEB. out_valid rises exactly 32 cycles after accept; out_tag equals in_tag.
- mulh 0x80000000 × 0x80000000 → 0x40000000. mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. mulhsu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- div 0xFFFFFFF9 / 2 → 0xFFFFFFFD. rem same operands → 0xFFFFFFFF. divu 100 / 7 → 14. remu → 2.
- Corner cases, each with 1-cycle latency:
  - divu 5 / 0 → 0xFFFFFFFF with out_div_zero = 1.
  - rem 5 / 0 → 5.
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000; rem → 0.
  - aluop 3 → out_illegal = 1, result 0.
- Backpressure: hold out_ready low for 10 cycles in DONE. Outputs stay stable and in_ready stays low. The cycle after out_ready is asserted, in_ready = 1.
- Assert flush at iteration 10 of a div: IDLE next cycle and no out_valid ever. A following mul is accepted and correct. Repeat with rst_n low mid-CALC: same outcome.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the execute-stage ALUs. Holds the
//               6-bit aluop codes of the M extension and the state encoding
//               of the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [5:0] ALUOP_MULH   = 6'd16;
  localparam logic [5:0] ALUOP_MULHSU = 6'd17;
  localparam logic [5:0] ALUOP_MULHU  = 6'd18;
  localparam logic [5:0] ALUOP_MUL    = 6'd22;
  localparam logic [5:0] ALUOP_DIV    = 6'd24;
  localparam logic [5:0] ALUOP_DIVU   = 6'd26;
  localparam logic [5:0] ALUOP_REM    = 6'd28;
  localparam logic [5:0] ALUOP_REMU   = 6'd30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic is_mul_op(input logic [5:0] op);
    return op inside {ALUOP_MULH, ALUOP_MULHSU, ALUOP_MULHU, ALUOP_MUL};
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return op inside {ALUOP_DIV, ALUOP_DIVU, ALUOP_REM, ALUOP_REMU};
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_fixup.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_fixup
// Description : Combinational result fix-up for the iterative mul/div unit.
//               Applies the sign correction to the magnitude result and
//               selects the half / quotient / remainder for the opcode.
// Ports       : i_acc    - raw accumulator {hi, lo}: product, or
//                          {remainder, quotient} for divides
//               i_sign_a - dividend / multiplicand was negative
//               i_sign_b - divisor / multiplier was negative
//               i_op     - aluop of the operation
//               o_result - final XLEN-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_fixup
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic              i_sign_a,
  input  logic              i_sign_b,
  input  logic [5:0]        i_op,
  output logic [XLEN-1:0]   o_result
);

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;

  always_comb begin
    w_prod = (i_sign_a ^ i_sign_b) ? -i_acc : i_acc;
    w_quo  = (i_sign_a ^ i_sign_b) ? -i_acc[XLEN-1:0] : i_acc[XLEN-1:0];
    // Remainder follows the sign of the dividend.
    w_rem  = i_sign_a ? -i_acc[2*XLEN-1:XLEN] : i_acc[2*XLEN-1:XLEN];

    case (i_op)
      ALUOP_MUL:                             o_result = w_prod[XLEN-1:0];
      ALUOP_MULH, ALUOP_MULHSU, ALUOP_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
      ALUOP_DIV, ALUOP_DIVU:                 o_result = w_quo;
      ALUOP_REM, ALUOP_REMU:                 o_result = w_rem;
      default:                               o_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_iter
// Description : Iterative RV32M/RV64M multiply/divide unit. Shift-add
//               multiplier and restoring divider on operand magnitudes,
//               one bit per cycle, with valid/ready handshakes and flush.
// Ports       : clk, rst_n (sync, active-low), flush (kill in-flight op)
//               in_valid/in_ready, in_aluop, in_a, in_b, in_tag - request
//               out_valid/out_ready, out_result, out_tag,
//               out_div_zero, out_illegal                    - response
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_aluop,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div_zero,
  output logic             out_illegal
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] C_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     r_state, w_state_next;
  logic [CNT_W-1:0]  r_count;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mag_b;
  logic              r_is_div, r_sign_a, r_sign_b;
  logic [5:0]        r_op;

  logic              w_accept, w_is_mul, w_is_div, w_illegal;
  logic              w_sign_a, w_sign_b, w_b_zero, w_ovf, w_short;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_short_result, w_fix_result;
  logic [2*XLEN-1:0] w_step_in, w_step_out;
  logic [XLEN-1:0]   w_step_b;
  logic              w_step_div;
  logic [XLEN:0]     w_mul_sum, w_div_shift, w_div_diff;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid & in_ready & ~flush;

  // Request decode: signedness, magnitudes and short-circuit detection.
  always_comb begin
    w_is_mul  = is_mul_op(in_aluop);
    w_is_div  = is_div_op(in_aluop);
    w_illegal = ~(w_is_mul | w_is_div);
    w_sign_a  = in_a[XLEN-1] & (in_aluop inside {ALUOP_MULH, ALUOP_MULHSU, ALUOP_DIV, ALUOP_REM});
    w_sign_b  = in_b[XLEN-1] & (in_aluop inside {ALUOP_MULH, ALUOP_DIV, ALUOP_REM});
    w_mag_a   = w_sign_a ? -in_a : in_a;
    w_mag_b   = w_sign_b ? -in_b : in_b;
    w_b_zero  = (in_b == '0);
    w_ovf     = (in_aluop inside {ALUOP_DIV, ALUOP_REM}) & (in_a == C_MOST_NEG) & (in_b == '1);
    w_short   = w_illegal | (w_is_div & (w_b_zero | w_ovf));

    w_short_result = '0;
    if (w_is_div && w_b_zero)
      w_short_result = (in_aluop inside {ALUOP_DIV, ALUOP_DIVU}) ? '1 : in_a;
    else if (w_is_div && w_ovf)
      w_short_result = (in_aluop == ALUOP_DIV) ? in_a : '0;
  end

  // One mul/div iteration. The first iteration runs on the accept edge
  // straight from the decoded operands, so CALC needs only XLEN-1 cycles
  // and the result lands XLEN cycles after accept.
  // Accumulator layout: {hi, lo}. Multiply: hi = partial product, lo =
  // remaining multiplier bits. Divide: hi = partial remainder, lo = dividend
  // bits shifting out at the top while quotient bits shift in at the bottom.
  always_comb begin
    if (r_state == IDLE) begin
      w_step_in  = {{XLEN{1'b0}}, w_mag_a};
      w_step_b   = w_mag_b;
      w_step_div = w_is_div;
    end else begin
      w_step_in  = r_acc;
      w_step_b   = r_mag_b;
      w_step_div = r_is_div;
    end

    w_mul_sum   = {1'b0, w_step_in[2*XLEN-1:XLEN]} + (w_step_in[0] ? {1'b0, w_step_b} : '0);
    w_div_shift = {w_step_in[2*XLEN-1:XLEN], w_step_in[XLEN-1]};
    w_div_diff  = w_div_shift - {1'b0, w_step_b};

    if (w_step_div) begin
      if (w_div_diff[XLEN])  // borrow: restore
        w_step_out = {w_div_shift[XLEN-1:0], w_step_in[XLEN-2:0], 1'b0};
      else
        w_step_out = {w_div_diff[XLEN-1:0], w_step_in[XLEN-2:0], 1'b1};
    end else begin
      w_step_out = {w_mul_sum, w_step_in[XLEN-1:1]};
    end
  end

  muldiv_fixup #(.XLEN(XLEN)) u_fixup (
    .i_acc    (w_step_out),
    .i_sign_a (r_sign_a),
    .i_sign_b (r_sign_b),
    .i_op     (r_op),
    .o_result (w_fix_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_state_next = w_short ? DONE : CALC;
        CALC:    if (r_count == CNT_W'(2)) w_state_next = DONE;
        DONE:    if (out_ready) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_acc        <= '0;
      r_mag_b      <= '0;
      r_is_div     <= 1'b0;
      r_sign_a     <= 1'b0;
      r_sign_b     <= 1'b0;
      r_op         <= '0;
      out_result   <= '0;
      out_tag      <= '0;
      out_div_zero <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_acc        <= w_step_out;
      r_mag_b      <= w_mag_b;
      r_is_div     <= w_is_div;
      r_sign_a     <= w_sign_a;
      r_sign_b     <= w_sign_b;
      r_op         <= in_aluop;
      r_count      <= CNT_W'(XLEN);
      out_tag      <= in_tag;
      out_div_zero <= w_is_div & w_b_zero;
      out_illegal  <= w_illegal;
      if (w_short) out_result <= w_short_result;
    end else if (r_state == CALC && !flush) begin
      r_acc   <= w_step_out;
      r_count <= r_count - CNT_W'(1);
      if (r_count == CNT_W'(2)) out_result <= w_fix_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_iter
// Description : Directed self-checking bench for alu_muldiv_iter (XLEN=32).
//               Latency is counted as the number of cycles from the accept
//               edge until out_valid is seen (short-circuit = 1, iterative
//               path = XLEN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_iter;
  import alu_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [5:0]       in_aluop = '0;
  logic [XLEN-1:0]  in_a = '0;
  logic [XLEN-1:0]  in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_div_zero;
  logic             out_illegal;

  int errors = 0;
  int checks = 0;

  alu_muldiv_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_aluop     (in_aluop),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_tag      (out_tag),
    .out_div_zero (out_div_zero),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one op for a single cycle, then scramble the operand pins so any
  // late sampling shows up as a wrong result.
  task automatic accept(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
    check("in_ready before accept", in_ready, 1);
    in_valid = 1'b1;
    in_aluop = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_aluop = 6'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    in_tag   = 5'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      if (out_valid) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp_res,
                        input int exp_lat, input logic exp_dz, input logic exp_ill, input int hold);
    int lat;
    accept(op, a, b, tag);
    wait_valid(lat);
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, out_result, exp_res);
    check({name, " tag"}, out_tag, tag);
    check({name, " div_zero"}, out_div_zero, exp_dz);
    check({name, " illegal"}, out_illegal, exp_ill);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, " hold valid"}, out_valid, 1);
      check({name, " hold result"}, out_result, exp_res);
      check({name, " hold tag"}, out_tag, tag);
      check({name, " hold in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " in_ready after take"}, in_ready, 1);
    check({name, " valid after take"}, out_valid, 0);
  endtask

  initial begin
    int seen;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset out_result", out_result, 0);
    check("reset out_tag", out_tag, 0);
    check("reset div_zero", out_div_zero, 0);
    check("reset illegal", out_illegal, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Iterative path.
    run_op("mul",    ALUOP_MUL,    32'd7,        32'hFFFFFFFD, 5'h13, 32'hFFFFFFEB, 32, 0, 0, 0);
    run_op("mulh",   ALUOP_MULH,   32'h80000000, 32'h80000000, 5'h01, 32'h40000000, 32, 0, 0, 0);
    run_op("mulhu",  ALUOP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'h02, 32'hFFFFFFFE, 32, 0, 0, 0);
    run_op("mulhsu", ALUOP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h03, 32'hFFFFFFFF, 32, 0, 0, 0);
    run_op("div",    ALUOP_DIV,    32'hFFFFFFF9, 32'd2,        5'h04, 32'hFFFFFFFD, 32, 0, 0, 0);
    run_op("rem",    ALUOP_REM,    32'hFFFFFFF9, 32'd2,        5'h05, 32'hFFFFFFFF, 32, 0, 0, 0);
    run_op("divu",   ALUOP_DIVU,   32'd100,      32'd7,        5'h06, 32'd14,       32, 0, 0, 0);
    run_op("remu",   ALUOP_REMU,   32'd100,      32'd7,        5'h07, 32'd2,        32, 0, 0, 0);

    // Short-circuit corner cases.
    run_op("divu by 0", ALUOP_DIVU, 32'd5,        32'd0,        5'h08, 32'hFFFFFFFF, 1, 1, 0, 0);
    run_op("rem by 0",  ALUOP_REM,  32'd5,        32'd0,        5'h09, 32'd5,        1, 1, 0, 0);
    run_op("div ovf",   ALUOP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'h0A, 32'h80000000, 1, 0, 0, 0);
    run_op("rem ovf",   ALUOP_REM,  32'h80000000, 32'hFFFFFFFF, 5'h0B, 32'd0,        1, 0, 0, 0);
    run_op("illegal",   6'd3,       32'd123,      32'd456,      5'h0C, 32'd0,        1, 0, 1, 0);

    // Backpressure: result held for 10 cycles with out_ready low.
    run_op("backpressure", ALUOP_MUL, 32'd1000, 32'd1000, 5'h1F, 32'd1000000, 32, 0, 0, 10);

    // Flush at iteration 10 of a divide.
    accept(ALUOP_DIV, 32'd1000, 32'd3, 5'h11);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in_ready", in_ready, 1);
    check("flush out_valid", out_valid, 0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    check("flush no late valid", seen, 0);
    run_op("mul after flush", ALUOP_MUL, 32'd12, 32'd11, 5'h12, 32'd132, 32, 0, 0, 0);

    // Reset mid-CALC.
    accept(ALUOP_DIV, 32'd1000, 32'd3, 5'h14);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst mid-calc in_ready", in_ready, 1);
    check("rst mid-calc out_valid", out_valid, 0);
    check("rst mid-calc out_result", out_result, 0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    check("rst no late valid", seen, 0);
    run_op("mul after rst", ALUOP_MUL, 32'hFFFFFFFF, 32'd2, 5'h15, 32'hFFFFFFFE, 32, 0, 0, 0);

    // flush together with in_valid: no accept.
    in_valid = 1'b1;
    in_aluop = 6'd3;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush+valid in_ready", in_ready, 1);
    check("flush+valid out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
